// File: rtl/fff_pkg.sv
// Shared types and constants for the fastest-finger-first buzzer arbiter.
package fff_pkg;

    localparam int unsigned MAX_PLAYERS = 15;
    localparam int unsigned ID_W        = 4;
    localparam int unsigned SEG_W       = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        TIMEOUT = 2'd3
    } fff_state_e;

    // Segment order is {g,f,e,d,c,b,a}, active high
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1111001;

    // Index of the lowest set bit; 0 when the vector is empty
    function automatic logic [ID_W-1:0] lowest_set(input logic [MAX_PLAYERS-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fff_seg_decode.sv
// Combinational hex digit to seven-segment pattern, {g,f,e,d,c,b,a} active high.
module fff_seg_decode
    import fff_pkg::*;
(
    input  logic [ID_W-1:0]  hex_i,
    output logic [SEG_W-1:0] seg_c
);

    // Full 16-entry hex table
    always_comb begin
        seg_c = SEG_BLANK;
        case (hex_i)
            4'h0: seg_c = 7'b0111111;
            4'h1: seg_c = 7'b0000110;
            4'h2: seg_c = 7'b1011011;
            4'h3: seg_c = 7'b1001111;
            4'h4: seg_c = 7'b1100110;
            4'h5: seg_c = 7'b1101101;
            4'h6: seg_c = 7'b1111101;
            4'h7: seg_c = 7'b0000111;
            4'h8: seg_c = 7'b1111111;
            4'h9: seg_c = 7'b1101111;
            4'hA: seg_c = 7'b1110111;
            4'hB: seg_c = 7'b1111100;
            4'hC: seg_c = 7'b0111001;
            4'hD: seg_c = 7'b1011110;
            4'hE: seg_c = 7'b1111001;
            4'hF: seg_c = 7'b1110001;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/fff_buzzer_arbiter.sv
// Quiz-box front end: synchronises buttons, arbitrates the first valid press,
// tracks early-press fouls, times out the answer window and drives the display.
module fff_buzzer_arbiter
    import fff_pkg::*;
#(
    parameter int unsigned N_PLAYERS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_PLAYERS-1:0] buzz_n,
    input  logic                 arm,
    input  logic                 clear,
    output logic                 winner_valid,
    output logic [ID_W-1:0]      winner_id,
    output logic [N_PLAYERS-1:0] foul,
    output logic                 timed_out,
    output logic [SEG_W-1:0]     seg
);

    localparam int unsigned TIMER_W =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(TIMEOUT_CYCLES);

    logic [N_PLAYERS-1:0] sync1_q;
    logic [N_PLAYERS-1:0] sync2_q;
    logic [N_PLAYERS-1:0] prev_q;
    logic [N_PLAYERS-1:0] press_c;
    logic [N_PLAYERS-1:0] elig_c;

    fff_state_e           state_q, state_d;
    logic [ID_W-1:0]      winner_q, winner_d;
    logic [N_PLAYERS-1:0] foul_q, foul_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 valid_q;
    logic                 tout_q;
    logic [SEG_W-1:0]     seg_q, seg_d;

    logic [ID_W-1:0]      digit_c;
    logic [SEG_W-1:0]     digit_seg_c;

    // Two-flop synchroniser plus previous-sample register; released level is 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= buzz_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // A press is a 1->0 transition of the synchronised button
    assign press_c = prev_q & ~sync2_q;
    assign elig_c  = press_c & ~foul_q;

    // Next-state logic: clear dominates, then per-state round rules
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        foul_d   = foul_q;
        timer_d  = timer_q;
        if (clear) begin
            state_d  = IDLE;
            winner_d = '0;
            foul_d   = '0;
            timer_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    foul_d = foul_q | press_c;
                    if (arm) begin
                        state_d = ARMED;
                        timer_d = TIMER_INIT;
                    end
                end
                ARMED: begin
                    if (|elig_c) begin
                        winner_d = lowest_set(MAX_PLAYERS'(elig_c));
                        state_d  = LOCKED;
                    end else if (timer_q != '0) begin
                        // A zero load (timeout disabled) never counts down
                        timer_d = timer_q - TIMER_W'(1);
                        if (timer_q == TIMER_W'(1)) begin
                            state_d = TIMEOUT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Display shows the 1-based winner number
    assign digit_c = winner_d + ID_W'(1);

    fff_seg_decode u_seg_decode (
        .hex_i (digit_c),
        .seg_c (digit_seg_c)
    );

    // Display pattern for the upcoming state so seg lands with the state change
    always_comb begin
        seg_d = SEG_BLANK;
        case (state_d)
            IDLE:    seg_d = SEG_BLANK;
            ARMED:   seg_d = SEG_DASH;
            LOCKED:  seg_d = digit_seg_c;
            TIMEOUT: seg_d = SEG_E;
            default: seg_d = SEG_BLANK;
        endcase
    end

    // State, round data and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            winner_q <= '0;
            foul_q   <= '0;
            timer_q  <= '0;
            valid_q  <= 1'b0;
            tout_q   <= 1'b0;
            seg_q    <= SEG_BLANK;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            foul_q   <= foul_d;
            timer_q  <= timer_d;
            valid_q  <= (state_d == LOCKED);
            tout_q   <= (state_d == TIMEOUT);
            seg_q    <= seg_d;
        end
    end

    assign winner_valid = valid_q;
    assign winner_id    = winner_q;
    assign foul         = foul_q;
    assign timed_out    = tout_q;
    assign seg          = seg_q;

endmodule

// File: tb/tb_fff_buzzer_arbiter.sv
// Self-checking bench for fff_buzzer_arbiter: directed scenarios plus a
// randomized run against a round-level reference model.
module tb_fff_buzzer_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] buzz_n;
    logic          arm;
    logic          clear;
    logic          winner_valid;
    logic [3:0]    winner_id;
    logic [NP-1:0] foul;
    logic          timed_out;
    logic [6:0]    seg;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: round mode 0=idle 1=armed 2=locked 3=timeout
    int            m_mode;
    int            m_win;
    int            m_deadline;
    int            cyc;
    logic [NP-1:0] m_foul;
    logic [NP-1:0] h0, h1, h2;   // button samples from 1, 2 and 3 edges ago

    always #5 clk = ~clk;

    fff_buzzer_arbiter #(.N_PLAYERS(NP), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .buzz_n       (buzz_n),
        .arm          (arm),
        .clear        (clear),
        .winner_valid (winner_valid),
        .winner_id    (winner_id),
        .foul         (foul),
        .timed_out    (timed_out),
        .seg          (seg)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lowest(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [6:0] digit_pattern(input int d);
        case (d)
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int mode, input int win);
        case (mode)
            1: return 7'b1000000;
            2: return digit_pattern(win + 1);
            3: return 7'b1111001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_win = 0; m_deadline = 0; m_foul = '0;
        h0 = '1; h1 = '1; h2 = '1;
    endtask

    // Advance the model by one clock edge using the inputs just sampled
    task automatic model_step();
        logic [NP-1:0] press;
        logic [NP-1:0] elig;
        press = h2 & ~h1;
        elig  = press & ~m_foul;
        if (clear) begin
            m_mode = 0; m_foul = '0; m_win = 0;
        end else begin
            case (m_mode)
                0: begin
                    m_foul = m_foul | press;
                    if (arm) begin
                        m_mode = 1;
                        m_deadline = cyc + int'(TO);
                    end
                end
                1: begin
                    if (elig != '0) begin
                        m_win = lowest(elig);
                        m_mode = 2;
                    end else if (TO != 0 && cyc == m_deadline) begin
                        m_mode = 3;
                    end
                end
                default: begin
                end
            endcase
        end
        h2 = h1; h1 = h0; h0 = buzz_n;
        cyc = cyc + 1;
    endtask

    // Drive inputs at the falling edge, let one rising edge act, return at next falling edge
    task automatic tick(input logic a, input logic c, input logic [NP-1:0] b);
        arm = a; clear = c; buzz_n = b;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; clear = 1'b0; buzz_n = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (winner_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", winner_valid); end
        n_cmp++; if (winner_id !== 4'd0) begin n_bad++; $display("FAIL reset_id: got %0d want 0", winner_id); end
        n_cmp++; if (foul !== 4'b0000) begin n_bad++; $display("FAIL reset_foul: got %b want 0000", foul); end
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timed_out); end
        n_cmp++; if (seg !== 7'b0000000) begin n_bad++; $display("FAIL reset_seg: got %b want 0000000", seg); end
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_single_press();
        tick(1'b1, 1'b0, 4'b1111);
        n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL arm_seg: got %b want 1000000", seg); end
        tick(1'b0, 1'b0, 4'b1011);
        tick(1'b0, 1'b0, 4'b1011);
        n_cmp++; if (winner_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got valid %b want 0 at k+1", winner_valid); end
        tick(1'b0, 1'b0, 4'b1011);
        n_cmp++; if (winner_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", winner_valid); end
        n_cmp++; if (winner_id !== 4'd2) begin n_bad++; $display("FAIL single_id: got %0d want 2", winner_id); end
        n_cmp++; if (seg !== 7'b1001111) begin n_bad++; $display("FAIL single_seg: got %b want 1001111", seg); end
        repeat (4) tick(1'b0, 1'b0, 4'b1010);
        n_cmp++; if (winner_id !== 4'd2) begin n_bad++; $display("FAIL single_hold: got %0d want 2", winner_id); end
        tick(1'b0, 1'b1, 4'b1010);
        n_cmp++; if (winner_valid !== 1'b0 || seg !== 7'b0000000) begin n_bad++; $display("FAIL clear_out: got valid %b seg %b want 0 0000000", winner_valid, seg); end
        repeat (3) tick(1'b0, 1'b0, 4'b1111);
    endtask

    task automatic test_tie();
        tick(1'b1, 1'b0, 4'b1111);
        repeat (3) tick(1'b0, 1'b0, 4'b0101);
        n_cmp++; if (winner_id !== 4'd1) begin n_bad++; $display("FAIL tie_id: got %0d want 1", winner_id); end
        n_cmp++; if (seg !== 7'b1011011) begin n_bad++; $display("FAIL tie_seg: got %b want 1011011", seg); end
        tick(1'b0, 1'b1, 4'b0101);
        repeat (3) tick(1'b0, 1'b0, 4'b1111);
    endtask

    task automatic test_foul_lockout();
        tick(1'b0, 1'b0, 4'b1110);
        repeat (3) tick(1'b0, 1'b0, 4'b1111);
        n_cmp++; if (foul !== 4'b0001) begin n_bad++; $display("FAIL foul_set: got %b want 0001", foul); end
        tick(1'b1, 1'b0, 4'b1111);
        repeat (3) tick(1'b0, 1'b0, 4'b1110);
        n_cmp++; if (winner_valid !== 1'b0 || seg !== 7'b1000000) begin n_bad++; $display("FAIL foul_ignored: got valid %b seg %b want 0 1000000", winner_valid, seg); end
        repeat (3) tick(1'b0, 1'b0, 4'b0110);
        n_cmp++; if (winner_id !== 4'd3) begin n_bad++; $display("FAIL foul_winner: got %0d want 3", winner_id); end
        n_cmp++; if (seg !== 7'b1100110) begin n_bad++; $display("FAIL foul_seg: got %b want 1100110", seg); end
        n_cmp++; if (foul !== 4'b0001) begin n_bad++; $display("FAIL foul_sticky: got %b want 0001", foul); end
        tick(1'b0, 1'b1, 4'b0110);
        repeat (3) tick(1'b0, 1'b0, 4'b1111);
    endtask

    task automatic test_timeout();
        tick(1'b1, 1'b0, 4'b1111);
        repeat (TO - 1) tick(1'b0, 1'b0, 4'b1111);
        n_cmp++; if (timed_out !== 1'b0 || seg !== 7'b1000000) begin n_bad++; $display("FAIL timeout_early: got to %b seg %b want 0 1000000", timed_out, seg); end
        tick(1'b0, 1'b0, 4'b1111);
        n_cmp++; if (timed_out !== 1'b1) begin n_bad++; $display("FAIL timeout_flag: got %b want 1", timed_out); end
        n_cmp++; if (seg !== 7'b1111001) begin n_bad++; $display("FAIL timeout_seg: got %b want 1111001", seg); end
        repeat (3) tick(1'b0, 1'b0, 4'b1011);
        n_cmp++; if (timed_out !== 1'b1 || winner_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_hold: got to %b valid %b want 1 0", timed_out, winner_valid); end
        tick(1'b0, 1'b1, 4'b1011);
        repeat (3) tick(1'b0, 1'b0, 4'b1111);
    endtask

    task automatic test_held_and_clear();
        repeat (3) tick(1'b0, 1'b0, 4'b1101);
        tick(1'b1, 1'b0, 4'b1101);
        repeat (2) tick(1'b0, 1'b0, 4'b1101);
        n_cmp++; if (foul !== 4'b0010) begin n_bad++; $display("FAIL held_foul: got %b want 0010", foul); end
        n_cmp++; if (winner_valid !== 1'b0 || seg !== 7'b1000000) begin n_bad++; $display("FAIL held_nowin: got valid %b seg %b want 0 1000000", winner_valid, seg); end
        tick(1'b0, 1'b0, 4'b1111);
        tick(1'b0, 1'b0, 4'b1011);
        tick(1'b0, 1'b0, 4'b1011);
        tick(1'b0, 1'b1, 4'b1011);
        n_cmp++; if (winner_valid !== 1'b0 || seg !== 7'b0000000) begin n_bad++; $display("FAIL clear_prio: got valid %b seg %b want 0 0000000", winner_valid, seg); end
        n_cmp++; if (foul !== 4'b0000) begin n_bad++; $display("FAIL clear_foul: got %b want 0000", foul); end
        repeat (3) tick(1'b0, 1'b0, 4'b1111);
        n_cmp++; if (winner_valid !== 1'b0) begin n_bad++; $display("FAIL clear_stay: got valid %b want 0", winner_valid); end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b0, 4'b1111);
        repeat (3) tick(1'b0, 1'b0, 4'b1101);
        n_cmp++; if (winner_valid !== 1'b1) begin n_bad++; $display("FAIL async_pre: got valid %b want 1", winner_valid); end
        #2;
        rst_n = 1'b0; buzz_n = '1;
        #1;
        n_cmp++; if (winner_valid !== 1'b0 || winner_id !== 4'd0 || timed_out !== 1'b0 || seg !== 7'b0000000)
            begin n_bad++; $display("FAIL async_out: got valid %b id %0d to %b seg %b want all 0", winner_valid, winner_id, timed_out, seg); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) tick(1'b0, 1'b0, 4'b1111);
        n_cmp++; if (foul !== 4'b0000 || seg !== 7'b0000000) begin n_bad++; $display("FAIL async_after: got foul %b seg %b want 0000 0000000", foul, seg); end
    endtask

    task automatic test_random();
        logic [NP-1:0] b;
        logic          a;
        logic          c;
        b = '1;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NP; i++) if ($urandom_range(5) == 0) b[i] = ~b[i];
            a = ($urandom_range(5) == 0);
            c = ($urandom_range(19) == 0);
            tick(a, c, b);
            n_cmp++; if (winner_valid !== (m_mode == 2)) begin n_bad++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, winner_valid, (m_mode == 2)); end
            n_cmp++; if (winner_id !== 4'(m_win)) begin n_bad++; $display("FAIL rnd_id @%0d: got %0d want %0d", cyc, winner_id, m_win); end
            n_cmp++; if (foul !== m_foul) begin n_bad++; $display("FAIL rnd_foul @%0d: got %b want %b", cyc, foul, m_foul); end
            n_cmp++; if (timed_out !== (m_mode == 3)) begin n_bad++; $display("FAIL rnd_timeout @%0d: got %b want %b", cyc, timed_out, (m_mode == 3)); end
            n_cmp++; if (seg !== exp_seg(m_mode, m_win)) begin n_bad++; $display("FAIL rnd_seg @%0d: got %b want %b", cyc, seg, exp_seg(m_mode, m_win)); end
        end
        tick(1'b0, 1'b1, 4'b1111);
    endtask

    initial begin
        model_reset();
        cyc = 0;
        test_reset();
        test_single_press();
        test_tie();
        test_foul_lockout();
        test_timeout();
        test_held_and_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
